pulse_stream_transmitter: RTL

Parametrised successor to the TinyQV pulse transmitter. Symbols are streamed through an internal FIFO instead of being read from a fixed 8-word program memory, so sequences can be any length while software refills the FIFO. Each symbol carries its own output level and raw duration. The block adds prescaling, optional carrier modulation, output inversion, a watermark request and underrun detection, and sits behind the peripheral register wrapper.

---
 rtl/pulse_stream_pkg.sv | 38 +++
 rtl/pulse_symbol_fifo.sv | 69 ++++++
 rtl/pulse_stream_transmitter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_stream_pkg.sv
// pulse_stream_pkg
//   Shared definitions for the pulse stream transmitter:
//   - state_t      : transmitter FSM states (IDLE, RUN, UNDERRUN)
//   - DUR_LSB      : lowest bit of the duration field inside a symbol
//   - sym_level_bit: position of the level bit for a given duration width
//   - PRESC_W      : width of the prescaler exponent (tick = 2^P clocks)
//   - presc_reload : prescaler counter reload value (2^P - 1)
package pulse_stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        UNDERRUN = 2'd2
    } state_t;

    // Symbol layout: {level, duration[DUR_W-1:0]}
    localparam int DUR_LSB = 0;

    localparam int PRESC_W = 4;
    // Counter wide enough to hold 2^(2^PRESC_W - 1) - 1
    localparam int PRESC_CNT_W = (1 << PRESC_W) - 1;

    // The level bit sits directly above the duration field.
    function automatic int sym_level_bit(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

    // Reload value for the prescaler: P low-order ones, i.e. 2^P - 1.
    function automatic logic [PRESC_CNT_W-1:0] presc_reload(input logic [PRESC_W-1:0] p);
        logic [PRESC_CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < PRESC_CNT_W; i++) begin
            if (i < int'(p)) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_symbol_fifo.sv
// pulse_symbol_fifo
//   Synchronous FIFO holding transmit symbols.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     push, wdata   : write request and data (ignored when full)
//     pop, rdata    : read request (ignored when empty); rdata shows the head
//     flush         : clears the FIFO; wins over a push in the same cycle
//     count         : current fill level
//     full, empty   : status flags
//   Pointers are log2(DEPTH) bits and wrap naturally because DEPTH is a
//   power of two.
module pulse_symbol_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic [LVL_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_CNT = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulse_stream_transmitter.sv
// pulse_stream_transmitter
//   Streams {level, duration} symbols from an internal FIFO onto pulse_out.
//   Each symbol is held for (D+1)*2^P clocks; symbols follow each other with
//   no gap while the FIFO has data.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     start/stop/flush    : single-cycle control pulses (stop beats start)
//     sym_valid/sym_data  : symbol push; sym_ready is high when not full
//     cfg_*               : prescaler, idle level, inversion, carrier and
//                           empty-FIFO policy, watermark threshold
//     pulse_out           : final output, carrier_out: raw carrier (RUN only)
//     busy, fifo_level    : status; wm_req high when busy and level <= wm
//     evt_done            : one-cycle pulse in the first IDLE cycle after
//                           the sequence drains with stop-on-empty set
//     evt_underrun        : one-cycle pulse on entering UNDERRUN
//
//   Handshake: a symbol is transferred on any clock edge where sym_valid and
//   sym_ready are both high; sym_data must be stable while sym_valid is high
//   and sym_ready does not depend on sym_valid.
module pulse_stream_transmitter
    import pulse_stream_pkg::*;
#(
    parameter int DUR_W = 16,
    parameter int DEPTH = 16,
    parameter int CAR_W = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               flush,
    input  logic               sym_valid,
    input  logic [DUR_W:0]     sym_data,
    output logic               sym_ready,
    input  logic [PRESC_W-1:0] cfg_prescaler,
    input  logic               cfg_idle_level,
    input  logic               cfg_invert,
    input  logic               cfg_carrier_en,
    input  logic [CAR_W-1:0]   cfg_carrier_half,
    input  logic               cfg_stop_on_empty,
    input  logic [LVL_W-1:0]   cfg_watermark,
    output logic               pulse_out,
    output logic               carrier_out,
    output logic               busy,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               wm_req,
    output logic               evt_done,
    output logic               evt_underrun
);

    localparam int LEVEL_BIT = sym_level_bit(DUR_W);

    state_t                 state;
    logic                   level_q;
    logic [DUR_W+3:0]       dur_cnt;
    logic [PRESC_W-1:0]     presc_q;
    logic [PRESC_CNT_W-1:0] pre_cnt;
    logic [CAR_W-1:0]       car_cnt;
    logic                   car_q;
    logic                   evt_done_q;
    logic                   evt_underrun_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DUR_W:0]   fifo_rdata;
    logic             accept;
    logic             sym_last;
    logic             bypass;
    logic             pop;
    logic             load;
    logic [DUR_W:0]   load_data;
    logic             in_run;
    logic             active;

    // Held low during reset so nothing is accepted before the FIFO is clear.
    assign sym_ready = !rst && !fifo_full;
    assign accept    = sym_valid && sym_ready;

    // Last clock of the held symbol: both counters have run out.
    assign sym_last  = (state == RUN) && (pre_cnt == '0) && (dur_cnt == '0);

    // In UNDERRUN the FIFO is empty, so the first pushed symbol goes straight
    // into the holding register instead of taking a detour through the FIFO.
    assign bypass    = (state == UNDERRUN) && !stop && fifo_empty && accept;

    assign pop       = !stop && !fifo_empty &&
                       (((state == IDLE) && start) || sym_last || (state == UNDERRUN));
    assign load      = pop || bypass;
    assign load_data = bypass ? sym_data : fifo_rdata;

    pulse_symbol_fifo #(
        .WIDTH (DUR_W + 1),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && !bypass),
        .wdata (sym_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .flush (flush),
        .count (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            level_q        <= 1'b0;
            dur_cnt        <= '0;
            presc_q        <= '0;
            pre_cnt        <= '0;
            car_cnt        <= '0;
            car_q          <= 1'b0;
            evt_done_q     <= 1'b0;
            evt_underrun_q <= 1'b0;
        end else begin
            evt_done_q     <= 1'b0;
            evt_underrun_q <= 1'b0;

            // Carrier free-runs; it is re-phased when RUN is entered from IDLE.
            if (car_cnt == cfg_carrier_half) begin
                car_cnt <= '0;
                car_q   <= ~car_q;
            end else begin
                car_cnt <= car_cnt + 1'b1;
            end

            // Symbol timing: prescaler ticks gate the duration countdown.
            if ((state == RUN) && !sym_last) begin
                if (pre_cnt == '0) begin
                    dur_cnt <= dur_cnt - 1'b1;
                    pre_cnt <= presc_reload(presc_q);
                end else begin
                    pre_cnt <= pre_cnt - 1'b1;
                end
            end

            if (load) begin
                level_q <= load_data[LEVEL_BIT];
                dur_cnt <= {4'b0000, load_data[DUR_LSB +: DUR_W]};
                presc_q <= cfg_prescaler;
                pre_cnt <= presc_reload(cfg_prescaler);
            end

            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            state   <= RUN;
                            car_cnt <= '0;
                            car_q   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sym_last && !load) begin
                            if (cfg_stop_on_empty) begin
                                state      <= IDLE;
                                evt_done_q <= 1'b1;
                            end else begin
                                state          <= UNDERRUN;
                                evt_underrun_q <= 1'b1;
                            end
                        end
                    end
                    UNDERRUN: begin
                        if (load) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The symbol level and carrier phase are registered; only the static
    // idle/invert configuration is applied afterwards, which lets pulse_out
    // follow cfg_idle_level ^ cfg_invert while reset is asserted.
    assign in_run       = (state == RUN);
    assign active       = level_q && (!cfg_carrier_en || car_q);
    assign pulse_out    = (in_run ? active : cfg_idle_level) ^ cfg_invert;
    assign carrier_out  = in_run && car_q;
    assign busy         = (state != IDLE);
    assign wm_req       = busy && (fifo_level <= cfg_watermark);
    assign evt_done     = evt_done_q;
    assign evt_underrun = evt_underrun_q;

endmodule
